sonar_scan_uc: RTL and testbench

- Parametrised control unit for the sonar sweep.
- Per angle position it:
  - triggers one distance measurement;
  - sends an N_CHARS-character frame through the serial TX, one character per handshake;
  - waits a programmable interval;
  - steps a bidirectional (ping-pong) angle index.
- Supports continuous or single-sweep mode, a graceful stop that completes the current frame, and a debug state output.
- Sits between the ultrasonic measurement block, the serial TX and the servo/angle ROM, in the top-level datapath.

---
 rtl/sonar_pkg.sv | 22 ++
 rtl/sonar_intervalo_timer.sv | 39 +++
 rtl/sonar_scan_uc.sv | 180 ++++++++++++++++++
 tb/tb_sonar_scan_uc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep controller: state encoding and the
// index-width helper used to size counters and index outputs.
package sonar_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL    = 4'd0,
    ST_PREPARACAO = 4'd1,
    ST_MEDE       = 4'd2,
    ST_ENVIA      = 4'd3,
    ST_AGUARDA    = 4'd4,
    ST_CONTA      = 4'd5,
    ST_ESPERA     = 4'd6,
    ST_GIRA       = 4'd7,
    ST_FINAL      = 4'd8
  } estado_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sonar_intervalo_timer.sv
// Modulo-M cycle counter. Held at zero while clr is high, advances while en is
// high, and flags the last count (M-1) on tc so the caller can leave after
// exactly M enabled cycles.
module sonar_intervalo_timer
  import sonar_pkg::*;
#(
  parameter int M = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = width_of(M);
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at M-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tc = en && !clr && (cnt_q == LAST);

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sonar_scan_uc.sv
// Sonar sweep control unit: per angle position it triggers one measurement,
// sends an N_CHARS-character frame, waits INTERVAL_CYCLES, then steps a
// ping-pong angle index. Optional measurement watchdog under MED_TIMEOUT_EN.
//
// state       | code | meaning
// inicial     | 0    | idle, datapath cleared, stop latch/angle/direction reset
// preparacao  | 1    | clear datapath, fire measurement, restart char index
// mede        | 2    | wait for measurement (or watchdog expiry)
// envia       | 3    | one-cycle serial start for current char
// aguarda     | 4    | wait for char sent
// conta       | 5    | advance char index
// espera      | 6    | inter-position interval
// gira        | 7    | step angle, flag sweep endpoint
// final       | 8    | sweep finished, pronto high
module sonar_scan_uc
  import sonar_pkg::*;
#(
  parameter int N_CHARS         = 8,
  parameter int N_POS           = 8,
  parameter int INTERVAL_CYCLES = 100000000,
  parameter int TIMEOUT_CYCLES  = 2500000,
  localparam int CW = width_of(N_CHARS),
  localparam int AW = width_of(N_POS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ligar,
  input  logic          parar,
  input  logic          modo,
  input  logic          pronto_medida,
  input  logic          pronto_transmissao,
  output logic          zera,
  output logic          medir,
  output logic          partida_serial,
  output logic [CW-1:0] indice_char,
  output logic [AW-1:0] angulo_idx,
  output logic          sentido,
  output logic          fim_varredura,
  output logic          erro_medida,
  output logic          pronto,
  output logic [3:0]    db_estado
);

  if (N_CHARS < 1 || N_POS < 1 || INTERVAL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sonar_scan_uc: all size/count parameters must be >= 1");
  end

  localparam logic [CW-1:0] LAST_CHAR = CW'(N_CHARS - 1);
  localparam logic [AW-1:0] LAST_POS  = AW'(N_POS - 1);

  estado_t       state_q, state_d;
  logic [CW-1:0] char_q, char_d;
  logic [AW-1:0] ang_q, ang_d;
  logic          sen_q, sen_d;
  logic          parar_q, parar_d;
  logic          erro_q, erro_d;
  logic          tc_espera;
  logic          tc_med;
  logic [AW-1:0] ang_step;
  logic          at_end;

  sonar_intervalo_timer #(.M(INTERVAL_CYCLES)) u_espera_timer (
    .clock (clock),
    .reset (reset),
    .clr   (state_q != ST_ESPERA),
    .en    (state_q == ST_ESPERA),
    .tc    (tc_espera)
  );

`ifdef MED_TIMEOUT_EN
  sonar_intervalo_timer #(.M(TIMEOUT_CYCLES)) u_med_watchdog (
    .clock (clock),
    .reset (reset),
    .clr   (state_q != ST_MEDE),
    .en    (state_q == ST_MEDE),
    .tc    (tc_med)
  );
`else
  assign tc_med = 1'b0;
`endif

  // Candidate next angle and endpoint detection; a single position never moves.
  always_comb begin
    ang_step = sen_q ? ang_q - 1'b1 : ang_q + 1'b1;
    if (N_POS == 1) ang_step = '0;
    at_end = (ang_step == '0) || (ang_step == LAST_POS);
  end

  // Next-state, register updates and Moore output decode.
  always_comb begin
    state_d        = state_q;
    char_d         = char_q;
    ang_d          = ang_q;
    sen_d          = sen_q;
    erro_d         = erro_q;
    parar_d        = (state_q == ST_INICIAL) ? 1'b0 : (parar_q | parar);
    zera           = 1'b0;
    medir          = 1'b0;
    partida_serial = 1'b0;
    fim_varredura  = 1'b0;
    pronto         = 1'b0;

    case (state_q)
      ST_INICIAL: begin
        zera   = 1'b1;
        ang_d  = '0;
        sen_d  = 1'b0;
        erro_d = 1'b0;
        if (ligar) state_d = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        zera    = 1'b1;
        medir   = 1'b1;
        char_d  = '0;
        state_d = ST_MEDE;
      end
      ST_MEDE: begin
        if (pronto_medida) begin
          state_d = ST_ENVIA;
        end else if (tc_med) begin
          state_d = ST_ENVIA;
          erro_d  = 1'b1;
        end
      end
      ST_ENVIA: begin
        partida_serial = 1'b1;
        state_d        = ST_AGUARDA;
      end
      ST_AGUARDA: begin
        if (pronto_transmissao) begin
          state_d = (char_q == LAST_CHAR) ? ST_ESPERA : ST_CONTA;
        end
      end
      ST_CONTA: begin
        char_d  = char_q + 1'b1;
        state_d = ST_ENVIA;
      end
      ST_ESPERA: begin
        if (tc_espera) state_d = parar_q ? ST_FINAL : ST_GIRA;
      end
      ST_GIRA: begin
        fim_varredura = at_end;
        ang_d         = ang_step;
        if (at_end) sen_d = ~sen_q;
        state_d = ((modo && at_end) || parar_q) ? ST_FINAL : ST_PREPARACAO;
      end
      ST_FINAL: begin
        pronto = 1'b1;
        if (ligar && !parar) state_d = ST_INICIAL;
      end
      default: state_d = ST_INICIAL;
    endcase
  end

  assign indice_char = char_q;
  assign angulo_idx  = ang_q;
  assign sentido     = sen_q;
  assign erro_medida = erro_q;
  assign db_estado   = state_q;

  // State and datapath-control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INICIAL;
      char_q  <= '0;
      ang_q   <= '0;
      sen_q   <= 1'b0;
      parar_q <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      ang_q   <= ang_d;
      sen_q   <= sen_d;
      parar_q <= parar_d;
      erro_q  <= erro_d;
    end
  end

endmodule

// File: tb/tb_sonar_scan_uc.sv
// Bench for sonar_scan_uc: directed scenarios with literal checks, then
// randomized stimulus, all compared every cycle against a phase-level model.
module tb_sonar_scan_uc;

  localparam int NC = 4;
  localparam int NP = 3;
  localparam int IV = 10;
  localparam int TO = 20;
`ifdef MED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, ligar, parar, modo, pronto_medida, pronto_transmissao;
  logic zera, medir, partida_serial, sentido, fim_varredura, erro_medida, pronto;
  logic [1:0] indice_char;
  logic [1:0] angulo_idx;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  sonar_scan_uc #(
    .N_CHARS(NC), .N_POS(NP), .INTERVAL_CYCLES(IV), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .parar(parar), .modo(modo),
    .pronto_medida(pronto_medida), .pronto_transmissao(pronto_transmissao),
    .zera(zera), .medir(medir), .partida_serial(partida_serial),
    .indice_char(indice_char), .angulo_idx(angulo_idx), .sentido(sentido),
    .fim_varredura(fim_varredura), .erro_medida(erro_medida), .pronto(pronto),
    .db_estado(db_estado)
  );

  int total = 0;
  int bad   = 0;

  // Model: phase number, char index, number of angle steps since idle,
  // cycles spent in the current timed phase, stop request, error flag.
  int ph = 0, ch = 0, steps = 0, wt = 0;
  bit stp = 0, er = 0;

  // Ping-pong position after s steps from 0.
  function automatic int ang_of(input int s);
    int p, m;
    if (NP == 1) return 0;
    p = 2 * (NP - 1);
    m = s % p;
    return (m <= NP - 1) ? m : p - m;
  endfunction

  // Direction flips each time an end is reached, i.e. every NP-1 steps.
  function automatic int sen_of(input int s);
    if (NP == 1) return s % 2;
    return (s / (NP - 1)) % 2;
  endfunction

  function automatic bit ep_at(input int s);
    if (NP == 1) return 1'b1;
    return (s % (NP - 1)) == 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait limit reached, got no event expected event", nm);
  endtask

  task automatic model_step();
    bit nstp;
    if (reset) begin
      ph = 0; ch = 0; steps = 0; wt = 0; stp = 0; er = 0;
      return;
    end
    nstp = (ph == 0) ? 1'b0 : (stp | parar);
    case (ph)
      0: begin steps = 0; er = 0; if (ligar) ph = 1; end
      1: begin ch = 0; wt = 0; ph = 2; end
      2: begin
        if (pronto_medida) ph = 3;
        else if (TO_EN && wt == TO - 1) begin ph = 3; er = 1; end
        else wt++;
      end
      3: ph = 4;
      4: if (pronto_transmissao) begin
           if (ch == NC - 1) begin ph = 6; wt = 0; end
           else ph = 5;
         end
      5: begin ch++; ph = 3; end
      6: if (wt == IV - 1) begin wt = 0; ph = stp ? 8 : 7; end else wt++;
      7: begin steps++; ph = ((modo && ep_at(steps)) || stp) ? 8 : 1; end
      8: if (ligar && !parar) ph = 0;
      default: ph = 0;
    endcase
    stp = nstp;
  endtask

  task automatic compare_all();
    chk("db_estado", int'(db_estado), ph);
    chk("zera", int'(zera), int'(ph == 0 || ph == 1));
    chk("medir", int'(medir), int'(ph == 1));
    chk("partida_serial", int'(partida_serial), int'(ph == 3));
    chk("indice_char", int'(indice_char), ch);
    chk("angulo_idx", int'(angulo_idx), ang_of(steps));
    chk("sentido", int'(sentido), sen_of(steps));
    chk("fim_varredura", int'(fim_varredura), int'(ph == 7 && ep_at(steps + 1)));
    chk("erro_medida", int'(erro_medida), int'(er));
    chk("pronto", int'(pronto), int'(ph == 8));
  endtask

  task automatic cyc(input bit l, input bit p, input bit mo,
                     input bit pm, input bit pt, input bit rs);
    ligar = l; parar = p; modo = mo;
    pronto_medida = pm; pronto_transmissao = pt; reset = rs;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  // Responds to measurement/transmission requests with random latency.
  task automatic auto_cyc(input bit l, input bit p, input bit mo);
    cyc(l, p, mo, (ph == 2) && ($urandom_range(0, 2) == 0),
        (ph == 4) && ($urandom_range(0, 1) == 0), 1'b0);
  endtask

  initial begin
    int n, prev, fims, pulses;
    bit seen7;
    int ang_seen[$];
    int exp_ang[6] = '{0, 1, 2, 1, 0, 1};

    // Reset and first frame.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_db_estado", int'(db_estado), 0);
    chk("rst_zera", int'(zera), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("start_prep", int'(db_estado), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("start_mede", int'(db_estado), 2);
    ang_seen.push_back(int'(angulo_idx));
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("held_mede", int'(db_estado), 2);
    cyc(0, 0, 0, 1, 0, 0);
    chk("first_partida", int'(partida_serial), 1);
    for (int c = 0; c < NC; c++) begin
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("char_at_tx_done", int'(indice_char), c);
      cyc(0, 0, 0, 0, 1, 0);
      if (c < NC - 1) begin
        cyc(0, 0, 0, 0, 0, 0);
        chk("next_partida", int'(partida_serial), 1);
      end
    end
    n = 0;
    while (db_estado == 4'd6 && n < 50) begin
      n++;
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk("espera_len", n, 10);

    // Continuous sweep.
    prev = int'(db_estado); fims = 0; n = 0;
    while (ang_seen.size() < 6 && n < 3000) begin
      auto_cyc(0, 0, 0);
      n++;
      if (fim_varredura) fims++;
      if (db_estado == 4'd2 && prev == 1) ang_seen.push_back(int'(angulo_idx));
      prev = int'(db_estado);
    end
    if (ang_seen.size() < 6) bound_fail("cont_frames");
    else for (int i = 0; i < 6; i++) chk("cont_angle", ang_seen[i], exp_ang[i]);
    chk("cont_fim_pulses", fims, 2);
    chk("cont_sentido", int'(sentido), 0);

    // Single sweep.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 0);
    n = 0; fims = 0;
    while (db_estado != 4'd8 && n < 1000) begin
      auto_cyc(0, 0, 1);
      n++;
      if (fim_varredura) fims++;
    end
    if (n >= 1000) bound_fail("single_final");
    chk("single_pronto", int'(pronto), 1);
    chk("single_angle", int'(angulo_idx), 2);
    chk("single_fim", fims, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("single_back_idle", int'(db_estado), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("single_angle_clr", int'(angulo_idx), 0);

    // Stop during aguarda of char 1.
    cyc(1, 0, 0, 0, 0, 0);
    n = 0;
    while (!(ph == 4 && ch == 1) && n < 500) begin
      auto_cyc(0, 0, 0);
      n++;
    end
    if (n >= 500) bound_fail("stop_reach");
    cyc(0, 1, 0, 0, 0, 0);
    n = 0; pulses = 0; seen7 = 0;
    while (db_estado != 4'd8 && n < 500) begin
      auto_cyc(0, 0, 0);
      n++;
      if (partida_serial) pulses++;
      if (db_estado == 4'd7) seen7 = 1;
    end
    if (n >= 500) bound_fail("stop_final");
    chk("stop_rest_chars", pulses, 2);
    chk("stop_no_gira", int'(seen7), 0);

    // Reset during envia of a later frame.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n = 0;
    while (!(db_estado == 4'd3 && indice_char == 2'd2 && angulo_idx == 2'd1) && n < 1000) begin
      auto_cyc(0, 0, 0);
      n++;
    end
    if (n >= 1000) bound_fail("envia_reach");
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_mid_db", int'(db_estado), 0);
    chk("rst_mid_partida", int'(partida_serial), 0);
    chk("rst_mid_char", int'(indice_char), 0);
    chk("rst_mid_angle", int'(angulo_idx), 0);

`ifdef MED_TIMEOUT_EN
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    n = 0;
    while (db_estado == 4'd2 && n < 100) begin
      n++;
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk("wd_mede_len", n, 20);
    chk("wd_erro", int'(erro_medida), 1);
    chk("wd_partida", int'(partida_serial), 1);
    cyc(0, 1, 0, 0, 0, 0);
    n = 0;
    while (db_estado != 4'd8 && n < 500) begin
      auto_cyc(0, 0, 0);
      n++;
    end
    if (n >= 500) bound_fail("wd_final");
    chk("wd_erro_sticky", int'(erro_medida), 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wd_erro_clr", int'(erro_medida), 0);
`endif

    // Randomized run.
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
